// File: rtl/prog_load_sequencer.sv
// Loads a host binary into the Briey on-chip RAM over the program_load AW/W port,
// then releases the core. One command = RAM hard reset, N line writes, settle, run.
module prog_load_sequencer #(
  parameter int ADDR_W        = 15,
  parameter int DATA_W        = 512,
  parameter int MAX_LINES     = 512,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  io_axiClk,
  input  logic                  io_asyncReset,
  input  logic                  cmd_start,
  input  logic [ADDR_W-1:0]     cmd_base_addr,
  input  logic [9:0]            cmd_num_lines,
  input  logic                  cmd_abort,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_W-1:0]     src_data,
  input  logic [DATA_W/8-1:0]   src_strb,
  output logic                  program_load_en,
  output logic                  program_load_ram_reset,
  output logic                  program_load_aw_valid,
  input  logic                  program_load_aw_ready,
  output logic [ADDR_W-1:0]     program_load_aw_payload_addr,
  output logic                  program_load_w_valid,
  input  logic                  program_load_w_ready,
  output logic [DATA_W-1:0]     program_load_w_payload_data,
  output logic [DATA_W/8-1:0]   program_load_w_payload_strb,
  output logic                  core_run,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  localparam int CNT_W = 16;
  localparam logic [9:0]        MAX_L     = 10'(MAX_LINES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMRST, S_ADDR, S_DATA, S_SETTLE, S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [9:0]        num_lines_q, num_lines_d;
  logic [9:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic              load_en_q, load_en_d;
  logic              ram_rst_q, ram_rst_d;
  logic              aw_valid_q, aw_valid_d;
  logic              core_run_q, core_run_d;
  logic              done_q, done_d;
  logic              cmd_err_q, cmd_err_d;

  logic in_data, aw_fire, w_fire, abort_pend, can_accept;

  assign in_data    = (state_q == S_DATA);
  assign aw_fire    = aw_valid_q & program_load_aw_ready;
  assign w_fire     = in_data & src_valid & program_load_w_ready;
  assign abort_pend = abort_q | cmd_abort;
  assign can_accept = (state_q == S_IDLE) || (state_q == S_RUN);

  // Next-state logic; control outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_lines_d = num_lines_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    cmd_err_d   = cmd_err_q;
    done_d      = 1'b0;

    if (cmd_start && !can_accept) cmd_err_d = 1'b1;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (cmd_start) begin
          if (cmd_num_lines <= MAX_L) begin
            base_d      = cmd_base_addr & LINE_MASK;
            num_lines_d = cmd_num_lines;
            idx_d       = '0;
            cnt_d       = '0;
            abort_d     = 1'b0;
            cmd_err_d   = 1'b0;
            state_d     = S_RAMRST;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_RAMRST: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (num_lines_q == 10'd0) ? S_SETTLE : S_ADDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ADDR: begin
        abort_d = abort_pend;
        if (aw_fire) state_d = abort_pend ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        abort_d = abort_pend;
        if (w_fire) begin
          if (abort_pend) begin
            state_d = S_IDLE;
          end else if (idx_q == num_lines_q - 10'd1) begin
            cnt_d   = '0;
            state_d = S_SETTLE;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_SETTLE: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) abort_d = 1'b0;

    busy_d     = (state_d == S_RAMRST) || (state_d == S_ADDR) ||
                 (state_d == S_DATA)   || (state_d == S_SETTLE);
    load_en_d  = (state_d == S_RAMRST) || (state_d == S_ADDR) || (state_d == S_DATA);
    ram_rst_d  = (state_d == S_RAMRST);
    aw_valid_d = (state_d == S_ADDR);
    core_run_d = (state_d == S_RUN);
  end

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_lines_q <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      load_en_q   <= 1'b0;
      ram_rst_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      core_run_q  <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_lines_q <= num_lines_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      load_en_q   <= load_en_d;
      ram_rst_q   <= ram_rst_d;
      aw_valid_q  <= aw_valid_d;
      core_run_q  <= core_run_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Address wraps naturally by truncation to ADDR_W bits.
  assign program_load_aw_payload_addr = base_q + ADDR_W'({idx_q, 6'b0});
  assign program_load_aw_valid        = aw_valid_q;
  assign program_load_w_valid         = in_data & src_valid;
  assign src_ready                    = in_data & program_load_w_ready;
  assign program_load_w_payload_data  = in_data ? src_data : '0;
  assign program_load_w_payload_strb  = in_data ? src_strb : '0;
  assign program_load_en              = load_en_q;
  assign program_load_ram_reset       = ram_rst_q;
  assign core_run                     = core_run_q;
  assign busy                         = busy_q;
  assign done                         = done_q;
  assign cmd_err                      = cmd_err_q;

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Randomized bench for prog_load_sequencer: a host source/RAM sink responder plus a
// line-list reference model of the expected AW addresses, W beats and timing.
module tb_prog_load_sequencer;

  typedef logic [511:0] val_t;

  logic         clock, reset;
  logic         cmdStart, cmdAbort;
  logic [14:0]  cmdBaseAddr;
  logic [9:0]   cmdNumLines;
  logic         srcValid, srcReady;
  logic [511:0] srcData;
  logic [63:0]  srcStrb;
  logic         loadEn, ramReset, awValid, awReady, wValid, wReady;
  logic [14:0]  awAddr;
  logic [511:0] wData;
  logic [63:0]  wStrb;
  logic         coreRun, busy, done, cmdErr;

  int errors = 0;
  int checks = 0;

  prog_load_sequencer dut (
    .io_axiClk                    (clock),
    .io_asyncReset                (reset),
    .cmd_start                    (cmdStart),
    .cmd_base_addr                (cmdBaseAddr),
    .cmd_num_lines                (cmdNumLines),
    .cmd_abort                    (cmdAbort),
    .src_valid                    (srcValid),
    .src_ready                    (srcReady),
    .src_data                     (srcData),
    .src_strb                     (srcStrb),
    .program_load_en              (loadEn),
    .program_load_ram_reset       (ramReset),
    .program_load_aw_valid        (awValid),
    .program_load_aw_ready        (awReady),
    .program_load_aw_payload_addr (awAddr),
    .program_load_w_valid         (wValid),
    .program_load_w_ready         (wReady),
    .program_load_w_payload_data  (wData),
    .program_load_w_payload_strb  (wStrb),
    .core_run                     (coreRun),
    .busy                         (busy),
    .done                         (done),
    .cmd_err                      (cmdErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Host line source contents and responder mode knobs
  logic [511:0] lines [8];
  logic [63:0]  strbs [8];
  int  nLines = 0;
  int  srcIdx = 0;
  bit  randMode = 0;
  bit  awHold = 0;
  bit  wHold = 0;

  // Observations collected by the monitor
  logic [14:0]  awLog [$];
  logic [511:0] wLog [$];
  logic [63:0]  sLog [$];
  int  cyc = 0;
  int  busyCyc, firstAwCyc, lastWCyc, doneCyc, doneCount, ramRstCount;
  bit  busySeen, wFire, awStallPrev, wStallPrev;
  logic [14:0]  prevAddr;
  logic [511:0] prevData;

  task automatic checkOutput(input string tag, input val_t observed, input val_t expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor samples on the falling edge; responder drives 2 time units after the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (busy && !busySeen) begin busySeen = 1; busyCyc = cyc; end
        if (ramReset) ramRstCount++;
        if (awValid && firstAwCyc < 0) firstAwCyc = cyc;
        if (awStallPrev) begin
          checkOutput("awHoldValid", val_t'(awValid), val_t'(1));
          checkOutput("awHoldAddr", val_t'(awAddr), val_t'(prevAddr));
        end
        if (wStallPrev) begin
          checkOutput("wHoldValid", val_t'(wValid), val_t'(1));
          checkOutput("wHoldData", wData, prevData);
        end
        awStallPrev = awValid && !awReady;
        wStallPrev  = wValid && !wReady;
        prevAddr = awAddr;
        prevData = wData;
        if (awValid && awReady) awLog.push_back(awAddr);
        if (wValid && wReady) begin
          wLog.push_back(wData);
          sLog.push_back(wStrb);
          lastWCyc = cyc;
          wFire = 1;
        end
        if (done) begin doneCount++; doneCyc = cyc; end
      end else begin
        awStallPrev = 0;
        wStallPrev = 0;
      end
      @(posedge clock);
      #2;
      begin
        bit keep;
        keep = srcValid && !wFire;
        if (wFire) srcIdx++;
        wFire = 0;
        awReady = awHold ? 1'b0 : (randMode ? 1'($urandom_range(0, 1)) : 1'b1);
        wReady  = wHold  ? 1'b0 : (randMode ? 1'($urandom_range(0, 1)) : 1'b1);
        if (srcIdx >= nLines) begin
          srcValid = 1'b0;
        end else begin
          if (!keep) srcValid = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
          srcData = lines[srcIdx];
          srcStrb = strbs[srcIdx];
        end
      end
    end
  end

  task automatic startCmd(input int base, input int n, input bit rnd);
    @(posedge clock);
    #1;
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 16; w++) lines[k][w*32 +: 32] = $urandom;
      strbs[k] = {$urandom, $urandom};
    end
    randMode = rnd;
    nLines = n;
    srcIdx = 0;
    srcValid = 1'b0;
    wFire = 0;
    awLog.delete(); wLog.delete(); sLog.delete();
    busySeen = 0; firstAwCyc = -1; lastWCyc = -1; doneCyc = -1;
    doneCount = 0; ramRstCount = 0;
    cmdBaseAddr = 15'(base);
    cmdNumLines = 10'(n);
    cmdStart = 1'b1;
    @(posedge clock);
    #1;
    cmdStart = 1'b0;
  endtask

  // Legal command: launch it and check the first cycle after acceptance.
  task automatic applyStimulus(input int base, input int n, input bit rnd);
    startCmd(base, n, rnd);
    @(negedge clock);
    checkOutput("startBusy", val_t'(busy), val_t'(1));
    checkOutput("startLoadEn", val_t'(loadEn), val_t'(1));
    checkOutput("startRamRst", val_t'(ramReset), val_t'(1));
    checkOutput("startCoreRun", val_t'(coreRun), val_t'(0));
    checkOutput("startErrClr", val_t'(cmdErr), val_t'(0));
  endtask

  task automatic waitDone(input int budget);
    int t = 0;
    while (doneCount == 0 && t < budget) begin
      @(posedge clock);
      t++;
    end
    checkOutput("doneSeen", val_t'(doneCount != 0), val_t'(1));
    @(negedge clock);
    checkOutput("donePulse", val_t'(done), val_t'(0));
    checkOutput("runCoreRun", val_t'(coreRun), val_t'(1));
    checkOutput("runBusy", val_t'(busy), val_t'(0));
    checkOutput("runLoadEn", val_t'(loadEn), val_t'(0));
  endtask

  task automatic waitAw(input int budget);
    int t = 0;
    while (awLog.size() == 0 && t < budget) begin
      @(posedge clock);
      t++;
    end
    checkOutput("awSeen", val_t'(awLog.size() != 0), val_t'(1));
  endtask

  // Reference: line k goes to ((base rounded down to 64) + 64k) mod 32 KiB with the k-th source line.
  task automatic verifyLoad(input int base, input int n, input bit strict);
    int lineBase = base & 32'h7FC0;
    checkOutput("awCount", val_t'(awLog.size()), val_t'(n));
    checkOutput("wCount", val_t'(wLog.size()), val_t'(n));
    for (int k = 0; k < n && k < awLog.size(); k++)
      checkOutput($sformatf("awAddr%0d", k), val_t'(awLog[k]), val_t'((lineBase + 64 * k) % 32768));
    for (int k = 0; k < n && k < wLog.size(); k++) begin
      checkOutput($sformatf("wData%0d", k), wLog[k], lines[k]);
      checkOutput($sformatf("wStrb%0d", k), val_t'(sLog[k]), val_t'(strbs[k]));
    end
    checkOutput("ramRstCycles", val_t'(ramRstCount), val_t'(16));
    checkOutput("doneCount", val_t'(doneCount), val_t'(1));
    if (n > 0) begin
      checkOutput("firstAwLat", val_t'(firstAwCyc - busyCyc), val_t'(16));
      checkOutput("settleLat", val_t'(doneCyc - lastWCyc), val_t'(3));
      if (strict) checkOutput("lineRate", val_t'(lastWCyc - firstAwCyc), val_t'(2 * n - 1));
    end else begin
      checkOutput("zeroLat", val_t'(doneCyc - busyCyc), val_t'(18));
      checkOutput("zeroNoAw", val_t'(firstAwCyc), val_t'(-1));
    end
  endtask

  initial begin
    reset = 1'b1;
    cmdStart = 1'b0; cmdAbort = 1'b0; cmdBaseAddr = '0; cmdNumLines = '0;
    srcValid = 1'b0; srcData = '0; srcStrb = '0; awReady = 1'b0; wReady = 1'b0;
    busySeen = 0; firstAwCyc = -1; lastWCyc = -1; doneCyc = -1;
    doneCount = 0; ramRstCount = 0; busyCyc = 0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetOutputs",
                val_t'({busy, loadEn, ramReset, awValid, wValid, srcReady, coreRun, done, cmdErr}),
                val_t'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("idleOutputs",
                val_t'({busy, loadEn, ramReset, awValid, wValid, srcReady, coreRun, done, cmdErr}),
                val_t'(0));

    $display("[TB] illegal line count");
    startCmd(16'h0100, 513, 0);
    repeat (3) @(negedge clock);
    checkOutput("illegalErr", val_t'(cmdErr), val_t'(1));
    checkOutput("illegalBusy", val_t'(busy), val_t'(0));
    checkOutput("illegalLoadEn", val_t'(loadEn), val_t'(0));
    checkOutput("illegalNoDone", val_t'(doneCount), val_t'(0));

    $display("[TB] basic load");
    applyStimulus(16'h0040, 3, 0);
    waitDone(500);
    verifyLoad(16'h0040, 3, 1);

    $display("[TB] wrap load");
    applyStimulus(16'h7FC0, 2, 0);
    waitDone(500);
    verifyLoad(16'h7FC0, 2, 1);

    $display("[TB] zero lines");
    applyStimulus(16'h1234, 0, 0);
    waitDone(500);
    verifyLoad(16'h1234, 0, 1);

    $display("[TB] backpressure loads");
    for (int it = 0; it < 6; it++) begin
      int b;
      b = int'($urandom_range(0, 32767));
      applyStimulus(b, 4, 1);
      waitDone(3000);
      verifyLoad(b, 4, 0);
    end

    $display("[TB] start during DATA");
    applyStimulus(16'h0200, 4, 0);
    waitAw(200);
    @(posedge clock);
    #1;
    cmdStart = 1'b1;
    @(posedge clock);
    #1;
    cmdStart = 1'b0;
    @(negedge clock);
    checkOutput("dataStartErr", val_t'(cmdErr), val_t'(1));
    waitDone(500);
    verifyLoad(16'h0200, 4, 1);
    checkOutput("errSticky", val_t'(cmdErr), val_t'(1));
    applyStimulus(16'h0400, 1, 0);
    waitDone(500);
    verifyLoad(16'h0400, 1, 1);

    $display("[TB] abort during ADDR stall");
    awHold = 1;
    applyStimulus(16'h0800, 3, 0);
    begin
      int t = 0;
      while (firstAwCyc < 0 && t < 200) begin @(posedge clock); t++; end
    end
    @(posedge clock);
    #1;
    cmdAbort = 1'b1;
    @(posedge clock);
    #1;
    cmdAbort = 1'b0;
    repeat (3) @(posedge clock);
    checkOutput("abortAwStillValid", val_t'(awValid), val_t'(1));
    awHold = 0;
    repeat (30) @(posedge clock);
    @(negedge clock);
    checkOutput("abortAwCount", val_t'(awLog.size()), val_t'(1));
    checkOutput("abortWCount", val_t'(wLog.size()), val_t'(0));
    checkOutput("abortNoDone", val_t'(doneCount), val_t'(0));
    checkOutput("abortIdle", val_t'({busy, loadEn, coreRun, awValid}), val_t'(0));

    $display("[TB] async reset mid DATA");
    wHold = 1;
    applyStimulus(16'h0C00, 4, 0);
    waitAw(200);
    @(posedge clock);
    #3;
    checkOutput("preResetWValid", val_t'(wValid), val_t'(1));
    reset = 1'b1;
    #1;
    checkOutput("resetMidOutputs",
                val_t'({busy, loadEn, ramReset, awValid, wValid, srcReady, coreRun, done, cmdErr}),
                val_t'(0));
    checkOutput("resetMidData", wData, val_t'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    wHold = 0;
    repeat (20) @(negedge clock);
    checkOutput("resetNoDone", val_t'(doneCount), val_t'(0));
    checkOutput("resetStaysIdle", val_t'({busy, coreRun}), val_t'(0));

    $display("[TB] recovery load");
    applyStimulus(16'h2000, 2, 0);
    waitDone(500);
    verifyLoad(16'h2000, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
